// File: rtl/pc_ctrl_ras.sv
// Fetch-stage program-counter controller with a circular return-address
// stack and an exception-return register. State updates on the falling edge.
module pc_ctrl_ras #(
  parameter int             AW        = 32,
  parameter int             RAS_DEPTH = 4,
  parameter logic [AW-1:0]  RESET_PC  = '0
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         enable_pc,
  output logic [AW-1:0]                current_pc,
  output logic [AW-1:0]                next_pc,
  input  logic [2:0]                   kind,
  input  logic                         sub_op_b,
  input  logic [2:0]                   sub_op_bz,
  input  logic                         reg_rt_ra_equal,
  input  logic                         reg_rt_zero,
  input  logic                         reg_rt_negative,
  input  logic [13:0]                  imm_14bit,
  input  logic [15:0]                  imm_16bit,
  input  logic [23:0]                  imm_24bit,
  input  logic [AW-1:0]                reg_rb_data,
  input  logic                         do_hazard,
  input  logic                         do_halt_pc,
  input  logic                         xREG1_do_jcache,
  input  logic                         do_jcache,
  input  logic [AW-1:0]                jcache_pc,
  input  logic                         do_interrupt,
  input  logic [AW-1:0]                interrupt_pc,
  input  logic                         do_iret,
  output logic                         do_flush_REG1,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ret_from_reg,
  output logic [AW-1:0]                epc
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [2:0] {
    K_SEQ    = 3'd0,
    K_BR14   = 3'd1,
    K_BR16   = 3'd2,
    K_J24    = 3'd3,
    K_JR     = 3'd4,
    K_CALL24 = 3'd5,
    K_CALLR  = 3'd6,
    K_RET    = 3'd7
  } kind_e;

  // Sign-extend a word offset to AW and scale it to a byte offset.
  function automatic logic signed [AW-1:0] ofs14(input logic signed [13:0] imm);
    return AW'(imm) <<< 1;
  endfunction

  function automatic logic signed [AW-1:0] ofs16(input logic signed [15:0] imm);
    return AW'(imm) <<< 1;
  endfunction

  function automatic logic signed [AW-1:0] ofs24(input logic signed [23:0] imm);
    return AW'(imm) <<< 1;
  endfunction

  // Zero-compare branch family; unassigned encodings are never taken.
  function automatic logic bz_taken(input logic [2:0] op, input logic zero, input logic neg);
    case (op)
      3'd0:    return zero;
      3'd1:    return !neg;
      3'd2:    return !zero && !neg;
      3'd3:    return zero || neg;
      3'd4:    return neg;
      3'd5:    return !zero;
      default: return 1'b0;
    endcase
  endfunction

  // Occupancy counter that pins at the stack depth once older entries wrap.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] cnt);
    return (cnt == CW'(RAS_DEPTH)) ? cnt : cnt + CW'(1);
  endfunction

  logic [AW-1:0]         ras_mem [RAS_DEPTH];
  logic [PW-1:0]         ras_ptr;
  logic [PW-1:0]         ras_ptr_inc;
  logic                  ras_empty;
  logic                  taken;
  logic                  redirect;
  logic                  is_call;
  logic                  is_ret;
  logic                  commit;
  logic                  push;
  logic                  pop;
  logic signed [AW-1:0]  offset;
  logic [AW-1:0]         target;
  kind_e                 kind_q;

  assign kind_q      = kind_e'(kind);
  assign ras_ptr_inc = ras_ptr + PW'(1);
  assign ras_empty   = (ras_count == '0);
  assign is_call     = (kind_q == K_CALL24) || (kind_q == K_CALLR);
  assign is_ret      = (kind_q == K_RET);

  // Decode the control-transfer kind into a taken flag, a target and the RET source.
  always_comb begin
    taken        = 1'b0;
    offset       = '0;
    target       = current_pc - AW'(4);
    ret_from_reg = 1'b0;
    case (kind_q)
      K_BR14: begin
        taken  = sub_op_b ? !reg_rt_ra_equal : reg_rt_ra_equal;
        offset = ofs14(imm_14bit);
        target = current_pc - AW'(4) + offset;
      end
      K_BR16: begin
        taken  = bz_taken(sub_op_bz, reg_rt_zero, reg_rt_negative);
        offset = ofs16(imm_16bit);
        target = current_pc - AW'(4) + offset;
      end
      K_J24, K_CALL24: begin
        taken  = 1'b1;
        offset = ofs24(imm_24bit);
        target = current_pc - AW'(4) + offset;
      end
      K_JR, K_CALLR: begin
        taken  = 1'b1;
        target = reg_rb_data;
      end
      K_RET: begin
        taken        = 1'b1;
        ret_from_reg = ras_empty;
        target       = ras_empty ? reg_rb_data : ras_mem[ras_ptr];
      end
      default: begin
        taken = 1'b0;
      end
    endcase
  end

  // A jcache-steered REG1 already fetched the right path, so no redirect here.
  assign redirect      = taken && !xREG1_do_jcache;
  assign next_pc       = redirect ? target : current_pc + AW'(4);
  assign do_flush_REG1 = redirect;

  // The stack only moves when the redirect itself lands in current_pc.
  assign commit = enable_pc && !do_iret && !do_interrupt && !do_hazard && !do_halt_pc && redirect;
  assign push   = commit && is_call;
  assign pop    = commit && is_ret && !ras_empty;

  // PC, epc and stack-pointer state with iret > interrupt > hold > jcache > next_pc.
  always_ff @(negedge clock) begin
    if (reset) begin
      current_pc <= RESET_PC;
      epc        <= '0;
      ras_count  <= '0;
      ras_ptr    <= '0;
    end else if (enable_pc) begin
      if (do_iret) begin
        current_pc <= epc;
      end else if (do_interrupt) begin
        current_pc <= interrupt_pc;
        epc        <= current_pc;
      end else if (do_hazard || do_halt_pc) begin
        current_pc <= current_pc;
      end else if (!redirect && do_jcache) begin
        current_pc <= jcache_pc;
      end else begin
        current_pc <= next_pc;
        if (push) begin
          ras_ptr   <= ras_ptr_inc;
          ras_count <= sat_inc(ras_count);
        end else if (pop) begin
          ras_ptr   <= ras_ptr - PW'(1);
          ras_count <= ras_count - CW'(1);
        end
      end
    end
  end

  // Return-address storage; overflow silently reuses the oldest slot.
  always_ff @(negedge clock) begin
    if (push && !reset) begin
      ras_mem[ras_ptr_inc] <= current_pc;
    end
  end

endmodule

// File: tb/tb_pc_ctrl_ras.sv
// Directed bench for pc_ctrl_ras: expectations are queued while stimulus is
// driven and checked when the DUT presents them.
module tb_pc_ctrl_ras;

  localparam int AW = 32;

  logic          clock = 1'b0;
  logic          reset;
  logic          enable_pc;
  logic [AW-1:0] current_pc;
  logic [AW-1:0] next_pc;
  logic [2:0]    kind;
  logic          sub_op_b;
  logic [2:0]    sub_op_bz;
  logic          reg_rt_ra_equal;
  logic          reg_rt_zero;
  logic          reg_rt_negative;
  logic [13:0]   imm_14bit;
  logic [15:0]   imm_16bit;
  logic [23:0]   imm_24bit;
  logic [AW-1:0] reg_rb_data;
  logic          do_hazard;
  logic          do_halt_pc;
  logic          xREG1_do_jcache;
  logic          do_jcache;
  logic [AW-1:0] jcache_pc;
  logic          do_interrupt;
  logic [AW-1:0] interrupt_pc;
  logic          do_iret;
  logic          do_flush_REG1;
  logic [2:0]    ras_count;
  logic          ret_from_reg;
  logic [AW-1:0] epc;

  pc_ctrl_ras #(.AW(AW), .RAS_DEPTH(4), .RESET_PC('0)) dut (
    .clock(clock), .reset(reset), .enable_pc(enable_pc),
    .current_pc(current_pc), .next_pc(next_pc), .kind(kind),
    .sub_op_b(sub_op_b), .sub_op_bz(sub_op_bz),
    .reg_rt_ra_equal(reg_rt_ra_equal), .reg_rt_zero(reg_rt_zero),
    .reg_rt_negative(reg_rt_negative), .imm_14bit(imm_14bit),
    .imm_16bit(imm_16bit), .imm_24bit(imm_24bit), .reg_rb_data(reg_rb_data),
    .do_hazard(do_hazard), .do_halt_pc(do_halt_pc),
    .xREG1_do_jcache(xREG1_do_jcache), .do_jcache(do_jcache),
    .jcache_pc(jcache_pc), .do_interrupt(do_interrupt),
    .interrupt_pc(interrupt_pc), .do_iret(do_iret),
    .do_flush_REG1(do_flush_REG1), .ras_count(ras_count),
    .ret_from_reg(ret_from_reg), .epc(epc)
  );

  always #5 clock = ~clock;

  localparam int S_PC = 0, S_NPC = 1, S_FL = 2, S_CNT = 3, S_RFR = 4, S_EPC = 5;

  typedef struct {
    string       tag;
    int          sig;
    logic [31:0] exp;
  } exp_t;

  exp_t comb_q[$];
  exp_t seq_q[$];
  int   tests  = 0;
  int   failed = 0;

  function automatic logic [31:0] observe(input int sig);
    case (sig)
      S_PC:    return current_pc;
      S_NPC:   return next_pc;
      S_FL:    return {31'd0, do_flush_REG1};
      S_CNT:   return {29'd0, ras_count};
      S_RFR:   return {31'd0, ret_from_reg};
      default: return epc;
    endcase
  endfunction

  task automatic expc(input string tag, input int sig, input logic [31:0] v);
    exp_t e;
    e.tag = tag; e.sig = sig; e.exp = v;
    comb_q.push_back(e);
  endtask

  task automatic exps(input string tag, input int sig, input logic [31:0] v);
    exp_t e;
    e.tag = tag; e.sig = sig; e.exp = v;
    seq_q.push_back(e);
  endtask

  task automatic compare(input exp_t e);
    logic [31:0] obs;
    obs = observe(e.sig);
    tests++;
    assert (obs === e.exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", e.tag, obs, e.exp);
    end
  endtask

  task automatic drain_comb();
    while (comb_q.size() > 0) compare(comb_q.pop_front());
  endtask

  task automatic drain_seq();
    while (seq_q.size() > 0) compare(seq_q.pop_front());
  endtask

  // One instruction slot: combinational outputs checked mid-cycle, state after the falling edge.
  task automatic step();
    @(posedge clock);
    drain_comb();
    @(negedge clock);
    #1;
    drain_seq();
  endtask

  task automatic idle();
    enable_pc = 1'b1; kind = 3'd0; sub_op_b = 1'b0; sub_op_bz = 3'd0;
    reg_rt_ra_equal = 1'b0; reg_rt_zero = 1'b0; reg_rt_negative = 1'b0;
    imm_14bit = '0; imm_16bit = '0; imm_24bit = '0; reg_rb_data = '0;
    do_hazard = 1'b0; do_halt_pc = 1'b0; xREG1_do_jcache = 1'b0;
    do_jcache = 1'b0; jcache_pc = '0; do_interrupt = 1'b0;
    interrupt_pc = '0; do_iret = 1'b0;
  endtask

  task automatic jr(input logic [31:0] dest);
    idle(); kind = 3'd4; reg_rb_data = dest;
    expc("jr_npc", S_NPC, dest);
    exps("jr_pc", S_PC, dest);
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset overrides a disabled PC and a pending interrupt.
    idle();
    reset = 1'b1; enable_pc = 1'b0; do_interrupt = 1'b1; interrupt_pc = 32'h999;
    @(negedge clock); #1;
    @(negedge clock); #1;
    exps("rst_pc", S_PC, 32'h0);
    exps("rst_epc", S_EPC, 32'h0);
    exps("rst_cnt", S_CNT, 32'h0);
    drain_seq();
    reset = 1'b0;
    idle();

    // Sequential fetch.
    for (int i = 0; i < 3; i++) begin
      expc("seq_npc", S_NPC, 32'(4 * i + 4));
      expc("seq_flush", S_FL, 32'h0);
      exps("seq_pc", S_PC, 32'(4 * i + 4));
      step();
    end

    jr(32'h100);

    // BLTZ taken with a negative offset.
    idle(); kind = 3'd2; sub_op_bz = 3'd4; reg_rt_negative = 1'b1; imm_16bit = 16'hFFFE;
    expc("bltz_npc", S_NPC, 32'hF8);
    expc("bltz_flush", S_FL, 32'h1);
    exps("bltz_pc", S_PC, 32'hF8);
    step();

    // BLTZ not taken.
    idle(); kind = 3'd2; sub_op_bz = 3'd4; imm_16bit = 16'hFFFE;
    expc("bltz_nt_npc", S_NPC, 32'hFC);
    expc("bltz_nt_flush", S_FL, 32'h0);
    exps("bltz_nt_pc", S_PC, 32'hFC);
    step();

    // Taken BEQ suppressed by jcache-steered REG1; jcache target is loaded.
    idle(); kind = 3'd1; reg_rt_ra_equal = 1'b1; imm_14bit = 14'h10;
    xREG1_do_jcache = 1'b1; do_jcache = 1'b1; jcache_pc = 32'h300;
    expc("xj_npc", S_NPC, 32'h100);
    expc("xj_flush", S_FL, 32'h0);
    exps("xj_pc", S_PC, 32'h300);
    step();

    // Taken BNE beats a jcache hit.
    idle(); kind = 3'd1; sub_op_b = 1'b1; imm_14bit = 14'h3FF0;
    do_jcache = 1'b1; jcache_pc = 32'h500;
    expc("bne_npc", S_NPC, 32'h2DC);
    expc("bne_flush", S_FL, 32'h1);
    exps("bne_pc", S_PC, 32'h2DC);
    step();

    jr(32'h40);

    // CALL then RET from stack, then RET from register.
    idle(); kind = 3'd5; imm_24bit = 24'h10;
    expc("call_npc", S_NPC, 32'h5C);
    exps("call_pc", S_PC, 32'h5C);
    exps("call_cnt", S_CNT, 32'h1);
    step();
    idle(); kind = 3'd7; reg_rb_data = 32'h200;
    expc("ret_npc", S_NPC, 32'h40);
    expc("ret_rfr", S_RFR, 32'h0);
    exps("ret_cnt", S_CNT, 32'h0);
    step();
    idle(); kind = 3'd7; reg_rb_data = 32'h200;
    expc("ret2_npc", S_NPC, 32'h200);
    expc("ret2_rfr", S_RFR, 32'h1);
    exps("ret2_pc", S_PC, 32'h200);
    exps("ret2_cnt", S_CNT, 32'h0);
    step();

    // Five CALLR from 0x200,0x1000..0x4000: the oldest entry is overwritten.
    for (int i = 0; i < 5; i++) begin
      idle(); kind = 3'd6; reg_rb_data = 32'((i + 1) * 32'h1000);
      exps("ovf_pc", S_PC, 32'((i + 1) * 32'h1000));
      exps("ovf_cnt", S_CNT, (i < 4) ? 32'(i + 1) : 32'h4);
      step();
    end
    for (int i = 0; i < 5; i++) begin
      idle(); kind = 3'd7; reg_rb_data = 32'h700;
      expc("pop_npc", S_NPC, (i < 4) ? 32'((4 - i) * 32'h1000) : 32'h700);
      expc("pop_rfr", S_RFR, (i < 4) ? 32'h0 : 32'h1);
      exps("pop_cnt", S_CNT, (i < 4) ? 32'(3 - i) : 32'h0);
      step();
    end

    // CALL held by hazard for two cycles, then committed exactly once.
    for (int i = 0; i < 2; i++) begin
      idle(); kind = 3'd5; imm_24bit = 24'h10; do_hazard = 1'b1;
      expc("hz_npc", S_NPC, 32'h71C);
      expc("hz_flush", S_FL, 32'h1);
      exps("hz_pc", S_PC, 32'h700);
      exps("hz_cnt", S_CNT, 32'h0);
      step();
    end
    idle(); kind = 3'd5; imm_24bit = 24'h10;
    exps("hz_go_pc", S_PC, 32'h71C);
    exps("hz_go_cnt", S_CNT, 32'h1);
    step();

    // enable_pc=0 freezes PC and stack.
    idle(); enable_pc = 1'b0; kind = 3'd7;
    expc("en0_npc", S_NPC, 32'h700);
    exps("en0_pc", S_PC, 32'h71C);
    exps("en0_cnt", S_CNT, 32'h1);
    step();

    jr(32'h80);

    // Interrupt, then iret together with interrupt.
    idle(); do_interrupt = 1'b1; interrupt_pc = 32'h1000;
    expc("int_npc", S_NPC, 32'h84);
    exps("int_pc", S_PC, 32'h1000);
    exps("int_epc", S_EPC, 32'h80);
    step();
    idle(); do_iret = 1'b1; do_interrupt = 1'b1; interrupt_pc = 32'h2000;
    exps("iret_pc", S_PC, 32'h80);
    exps("iret_epc", S_EPC, 32'h80);
    step();

    // A CALL coinciding with an interrupt leaves the stack alone.
    idle(); kind = 3'd5; imm_24bit = 24'h10; do_interrupt = 1'b1; interrupt_pc = 32'h3000;
    exps("intcall_pc", S_PC, 32'h3000);
    exps("intcall_cnt", S_CNT, 32'h1);
    step();

    // Reset mid-sequence discards the stack.
    idle(); reset = 1'b1; kind = 3'd5;
    exps("rst2_pc", S_PC, 32'h0);
    exps("rst2_cnt", S_CNT, 32'h0);
    exps("rst2_epc", S_EPC, 32'h0);
    step();
    reset = 1'b0;
    idle(); kind = 3'd7; reg_rb_data = 32'h44;
    expc("rst2_ret_npc", S_NPC, 32'h44);
    expc("rst2_ret_rfr", S_RFR, 32'h1);
    exps("rst2_ret_pc", S_PC, 32'h44);
    step();

    // Halt holds the PC.
    idle(); do_halt_pc = 1'b1;
    exps("halt_pc", S_PC, 32'h44);
    step();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/pc_ctrl_ras.md
Name: pc_ctrl_ras

Overview:
Parametrised program-counter controller; the next generation of the CPU fetch-stage PC logic.
- Resolves branches, jumps, calls and returns from the decode stage and produces current_pc and next_pc.
- Adds a circular return-address stack (RAS), an internal exception-return register (epc) and a configurable address width.
- Drives the REG1 flush and sits between the jump cache and instruction fetch.

Parameters:
AW, 32, PC/address width in bits (>=16)
RAS_DEPTH, 4, return-address stack entries (power of two, >=2)
RESET_PC, 0, value loaded into current_pc on reset

Ports:
clock  in  1  all state updates on falling edge
reset  in  1  synchronous, active-high
enable_pc  in  1  PC/RAS/epc update enable
current_pc  out  AW  fetch address register
next_pc  out  AW  combinational candidate PC
kind  in  3  0 SEQ, 1 BR14, 2 BR16, 3 J24, 4 JR, 5 CALL24, 6 CALLR, 7 RET
sub_op_b  in  1  0 BEQ, 1 BNE
sub_op_bz  in  3  0 BEQZ, 1 BGEZ, 2 BGTZ, 3 BLEZ, 4 BLTZ, 5 BNEZ, others never taken
reg_rt_ra_equal, reg_rt_zero, reg_rt_negative  in  1 each  condition flags
imm_14bit / imm_16bit / imm_24bit  in  14/16/24  word offsets
reg_rb_data  in  AW  register jump target
do_hazard, do_halt_pc  in  1 each  hold PC
xREG1_do_jcache  in  1  suppress redirect (jcache already steered)
do_jcache  in  1  jcache hit
jcache_pc  in  AW  jcache target
do_interrupt  in  1  take interrupt
interrupt_pc  in  AW  vector
do_iret  in  1  return from interrupt
do_flush_REG1  out  1  flush REG1
ras_count  out  clog2(RAS_DEPTH)+1  valid RAS entries
ret_from_reg  out  1  RET target taken from reg_rb_data
epc  out  AW  saved interrupt return address

Behaviour:
- Reset, on the falling edge with reset=1:
  - current_pc=RESET_PC, epc=0, ras_count=0, RAS pointer=0.
  - Reset overrides enable_pc and every other input.
- Taken-condition rules:
  - BR14 is taken on BEQ&equal or BNE&!equal.
  - BR16 taken conditions:
    - BEQZ: zero.
    - BGEZ: !neg.
    - BGTZ: !zero&!neg.
    - BLEZ: zero|neg.
    - BLTZ: neg.
    - BNEZ: !zero.
  - J24, JR, CALL24, CALLR and RET are always taken.
- Target computation (all arithmetic mod 2^AW):
  - Offsets: base = current_pc-4, plus sign-extended imm shifted left by 1.
  - JR and CALLR target = reg_rb_data.
  - RET target = RAS top if ras_count>0, else reg_rb_data, with ret_from_reg=1.
  - ret_from_reg=0 for all other kinds.
- Redirect select:
  - redirect = taken & !xREG1_do_jcache.
  - next_pc = redirect ? target : current_pc+4.
  - do_flush_REG1 = redirect. Purely combinational, independent of hazard and enable.
- current_pc update priority, evaluated only when enable_pc=1:
  1. do_iret: epc.
  2. do_interrupt: interrupt_pc, and epc<=current_pc.
  3. do_hazard or do_halt_pc: hold.
  4. !redirect & do_jcache: jcache_pc.
  5. Otherwise: next_pc.
- enable_pc=0 holds current_pc, epc and the RAS entirely.
- RAS commit happens only when priority level 5 is selected and redirect=1:
  - Push (CALL24, CALLR): entry[ptr+1]<=current_pc, ptr++, ras_count saturates at RAS_DEPTH.
  - On overflow the oldest entry is silently overwritten, modulo RAS_DEPTH.
  - Pop (RET with ras_count>0): ptr--, ras_count--.
  - RET with an empty RAS is a no-op on the stack.
- No RAS change when a call or return coincides with hazard, halt, interrupt or iret, or when it is suppressed by xREG1_do_jcache.
- Simultaneous do_iret and do_interrupt: iret wins, and epc is unchanged.
- Reset mid-sequence discards all RAS contents. Stale entries are unreachable because ras_count=0.

Test Plan:
- Reset, then SEQ for 3 cycles (enable=1) -> current_pc 0,4,8,12; do_flush_REG1=0.
- current_pc=0x100, kind=BR16, BLTZ, neg=1, imm_16bit=0xFFFE -> next_pc=0xF8, flush=1; next edge current_pc=0xF8.
- CALL24 at current_pc=0x40, imm_24bit=0x10 -> jumps to 0x5C, ras_count=1. Later RET -> target 0x40, ret_from_reg=0, ras_count=0. A second RET takes reg_rb_data=0x200, ret_from_reg=1.
- RAS_DEPTH=4 with 5 calls pushing A..E, then 5 returns -> targets E,D,C,B, then reg_rb_data; ras_count sequence 4,3,2,1,0,0.
- CALL24 with do_hazard=1 for 2 cycles -> current_pc held, flush=1, ras_count stays 0. Hazard drops -> push happens exactly once.
- do_interrupt at current_pc=0x80, interrupt_pc=0x1000 -> current_pc=0x1000, epc=0x80. Then do_iret together with do_interrupt -> current_pc=0x80, epc unchanged.
